// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_fsb.sv
// One-bit full subtractor cell: d = a - b - bin with borrow-out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (D = A - B - BIN), LSB first, one bit per clock.
// Optional signed-overflow output v is built only when SUB_OVERFLOW_EN is defined.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
`ifdef SUB_OVERFLOW_EN
  output logic             v,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is sampled on a rising edge; it is accepted only when busy=0
  // (IDLE or FIN). done is a one-cycle pulse in FIN and d/bout are valid from then on.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_next;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             bit_d, bit_bout;
  logic             last, accept;
`ifdef SUB_OVERFLOW_EN
  logic             a_msb, b_msb;
`endif

  full_subtractor_bit u_fsb (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // New difference bit enters from the MSB side so the result ends up LSB-aligned.
  assign d_next = (d_sh >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = start && (state_q != S_RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_RUN : S_IDLE;
      S_RUN:   state_d = last ? S_FIN : S_RUN;
      S_FIN:   state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      d_sh    <= '0;
      br      <= 1'b0;
      cnt     <= '0;
      d       <= '0;
      bout    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      v       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        d_sh  <= '0;
        br    <= bin;
        cnt   <= '0;
`ifdef SUB_OVERFLOW_EN
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
`endif
      end else if (state_q == S_RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        d_sh <= d_next;
        br   <= bit_bout;
        cnt  <= cnt + 1'b1;
        if (last) begin
          d    <= d_next;
          bout <= bit_bout;
`ifdef SUB_OVERFLOW_EN
          // On the last bit, bit_d is the sign of the result.
          v    <= (a_msb ^ b_msb) & (bit_d ^ a_msb);
`endif
        end
      end
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_FIN);
  assign dbg_state = state_q;

endmodule
